// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MIPS IF stage - word PC, next-PC select, imem handshake, IF/ID register
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   PC_OUT / PC_PLUS1          PC to the external incrementer and its +1 result
//   IMEM_REQ/ADDR/ACK/DATA     instruction-memory request and response
//   STALL                      hazard-unit hold of PC and IF/ID
//   BR_TAKEN/BR_TARGET         branch redirect from EX
//   JMP/JMP_TARGET             jump redirect from ID
//   IFID_INSTR/PC1/VALID       IF/ID pipeline register
module pc_fetch_unit #(
  parameter logic [29:0] RESET_VECTOR = 30'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [29:0] PC_OUT,
  input  logic [29:0] PC_PLUS1,
  output logic        IMEM_REQ,
  output logic [29:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_DATA,
  input  logic        STALL,
  input  logic        BR_TAKEN,
  input  logic [29:0] BR_TARGET,
  input  logic        JMP,
  input  logic [29:0] JMP_TARGET,
  output logic [31:0] IFID_INSTR,
  output logic [29:0] IFID_PC1,
  output logic        IFID_VALID
);
  typedef enum logic [1:0] {FETCH, HOLD, BUBBLE} state_t;
  state_t st, st_n;
  logic live;
  logic [29:0] pc, pc_n, hpc1, hpc1_n, ipc1_n;
  logic [31:0] hins, hins_n, iins_n;
  logic ival_n;
  // Branch is older than the jump in ID, so it wins the redirect.
  logic redir;
  logic [29:0] tgt;
  logic ack;
  assign redir = BR_TAKEN | JMP;
  assign tgt = BR_TAKEN ? BR_TARGET : JMP_TARGET;
  // live keeps the request low for the first cycle out of reset.
  assign IMEM_REQ = live & (st == FETCH);
  assign ack = IMEM_ACK & IMEM_REQ;
  assign PC_OUT = pc;
  assign IMEM_ADDR = pc;
  always_comb begin
    st_n = st;
    pc_n = pc;
    hins_n = hins;
    hpc1_n = hpc1;
    iins_n = IFID_INSTR;
    ipc1_n = IFID_PC1;
    ival_n = IFID_VALID;
    if (live)
      case (st)
        FETCH:
          if (ack) begin
            if (redir) begin
              pc_n = tgt;
              iins_n = NOP_INSTR;
              ipc1_n = '0;
              ival_n = 1'b0;
            end else if (STALL) begin
              hins_n = IMEM_DATA;
              hpc1_n = PC_PLUS1;
              st_n = HOLD;
            end else begin
              iins_n = IMEM_DATA;
              ipc1_n = PC_PLUS1;
              ival_n = 1'b1;
              pc_n = PC_PLUS1;
            end
          end else if (redir) begin
            pc_n = tgt;
            ival_n = 1'b0;
            st_n = BUBBLE;
          end else if (!STALL) begin
            ival_n = 1'b0;
            iins_n = NOP_INSTR;
          end
        HOLD:
          if (redir) begin
            pc_n = tgt;
            hins_n = '0;
            hpc1_n = '0;
            iins_n = NOP_INSTR;
            ipc1_n = '0;
            ival_n = 1'b0;
            st_n = FETCH;
          end else if (!STALL) begin
            iins_n = hins;
            ipc1_n = hpc1;
            ival_n = 1'b1;
            pc_n = PC_PLUS1;
            st_n = FETCH;
          end
        default: begin
          pc_n = redir ? tgt : pc;
          st_n = redir ? BUBBLE : FETCH;
        end
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= FETCH;
      live <= 1'b0;
      pc <= RESET_VECTOR;
      hins <= '0;
      hpc1 <= '0;
      IFID_INSTR <= NOP_INSTR;
      IFID_PC1 <= '0;
      IFID_VALID <= 1'b0;
    end else begin
      st <= st_n;
      live <= 1'b1;
      pc <= pc_n;
      hins <= hins_n;
      hpc1 <= hpc1_n;
      IFID_INSTR <= iins_n;
      IFID_PC1 <= ipc1_n;
      IFID_VALID <= ival_n;
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: vector table plus scoreboard for pc_fetch_unit
module tb_pc_fetch_unit;
  localparam logic [31:0] TAG = 32'h8C00_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  logic clk = 0, rst_n = 0;
  logic [29:0] pc_out, pc_plus1, imem_addr, br_target, jmp_target, ifid_pc1;
  logic imem_req, imem_ack, stall, br_taken, jmp, ifid_valid;
  logic [31:0] imem_data, ifid_instr;
  int errors = 0, checks = 0;
  typedef struct {
    logic stall, br;
    logic [29:0] brt;
    logic jmp;
    logic [29:0] jt;
    logic ack;
    logic [29:0] pc;
    logic req, val;
    logic [31:0] ins;
    logic [29:0] pc1;
  } vec_t;
  vec_t tbl[23];
  vec_t sbq[$];
  vec_t e;
  always #5 clk = ~clk;
  assign pc_plus1 = pc_out + 30'd1;
  assign imem_data = {imem_addr, 2'b00} ^ TAG;
  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .PC_OUT(pc_out), .PC_PLUS1(pc_plus1),
    .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr), .IMEM_ACK(imem_ack), .IMEM_DATA(imem_data),
    .STALL(stall), .BR_TAKEN(br_taken), .BR_TARGET(br_target), .JMP(jmp), .JMP_TARGET(jmp_target),
    .IFID_INSTR(ifid_instr), .IFID_PC1(ifid_pc1), .IFID_VALID(ifid_valid)
  );
  function automatic logic [31:0] d(input logic [29:0] a);
    return {a, 2'b00} ^ TAG;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [29:0] pc, input logic req, input logic val,
                         input logic [31:0] ins, input logic [29:0] pc1);
    chk({tag, " pc"}, {2'b0, pc_out}, {2'b0, pc});
    chk({tag, " addr"}, {2'b0, imem_addr}, {2'b0, pc});
    chk({tag, " req"}, {31'b0, imem_req}, {31'b0, req});
    chk({tag, " valid"}, {31'b0, ifid_valid}, {31'b0, val});
    chk({tag, " instr"}, ifid_instr, ins);
    chk({tag, " pc1"}, {2'b0, ifid_pc1}, {2'b0, pc1});
  endtask
  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 1, 30'h0, 1, 0, NOP, 30'h0};
    tbl[1]  = '{0, 0, 0, 0, 0, 1, 30'h1, 1, 1, d(30'h0), 30'h1};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 30'h2, 1, 1, d(30'h1), 30'h2};
    tbl[3]  = '{0, 0, 0, 0, 0, 1, 30'h3, 1, 1, d(30'h2), 30'h3};
    tbl[4]  = '{0, 0, 0, 0, 0, 1, 30'h4, 1, 1, d(30'h3), 30'h4};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 30'h4, 1, 0, NOP, 30'h4};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 30'h4, 1, 0, NOP, 30'h4};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 30'h5, 1, 1, d(30'h4), 30'h5};
    tbl[8]  = '{1, 0, 0, 0, 0, 1, 30'h5, 0, 1, d(30'h4), 30'h5};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 30'h5, 0, 1, d(30'h4), 30'h5};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 30'h6, 1, 1, d(30'h5), 30'h6};
    tbl[11] = '{0, 1, 30'h40, 1, 30'h80, 1, 30'h40, 1, 0, NOP, 30'h0};
    tbl[12] = '{0, 0, 0, 1, 30'h10, 0, 30'h10, 0, 0, NOP, 30'h0};
    tbl[13] = '{0, 0, 0, 0, 0, 1, 30'h10, 1, 0, NOP, 30'h0};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 30'h11, 1, 1, d(30'h10), 30'h11};
    tbl[15] = '{0, 0, 0, 1, 30'h3FFF_FFFF, 0, 30'h3FFF_FFFF, 0, 0, d(30'h10), 30'h11};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 30'h3FFF_FFFF, 1, 0, d(30'h10), 30'h11};
    tbl[17] = '{0, 0, 0, 0, 0, 1, 30'h0, 1, 1, d(30'h3FFF_FFFF), 30'h0};
    tbl[18] = '{1, 0, 0, 0, 0, 1, 30'h0, 0, 1, d(30'h3FFF_FFFF), 30'h0};
    tbl[19] = '{1, 1, 30'h20, 0, 0, 0, 30'h20, 1, 0, NOP, 30'h0};
    tbl[20] = '{1, 0, 0, 0, 0, 0, 30'h20, 1, 0, NOP, 30'h0};
    tbl[21] = '{0, 0, 0, 0, 0, 1, 30'h21, 1, 1, d(30'h20), 30'h21};
    tbl[22] = '{1, 0, 0, 0, 0, 1, 30'h21, 0, 1, d(30'h20), 30'h21};
    {stall, br_taken, br_target, jmp, jmp_target, imem_ack} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 30'h0, 0, 0, NOP, 30'h0);
    rst_n = 1;
    for (int i = 0; i < 23; i++) begin
      stall = tbl[i].stall;
      br_taken = tbl[i].br;
      br_target = tbl[i].brt;
      jmp = tbl[i].jmp;
      jmp_target = tbl[i].jt;
      imem_ack = tbl[i].ack;
      sbq.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk_all($sformatf("vec%0d", i), e.pc, e.req, e.val, e.ins, e.pc1);
    end
    stall = 0;
    imem_ack = 1;
    #2 rst_n = 0;
    #1;
    chk_all("async reset", 30'h0, 0, 0, NOP, 30'h0);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk_all("post reset", 30'h0, 1, 0, NOP, 30'h0);
    @(posedge clk);
    #1;
    chk_all("refetch", 30'h1, 1, 1, d(30'h0), 30'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
